pi_txn_queue: RTL and testbench
===============================

# pi_txn_queue

Pi-side transaction queue upstream of the Amiga 68000 bus engine. It decodes Pi register writes into complete bus commands (24-bit address, write data, FC, RW, byte strobes) and buffers them in a small FIFO. It issues one command at a time over a valid/ready handshake and collects read data and completion pulses from the bus engine. It drives the Pi-visible busy line, so the Pi can post several writes without waiting for each 68000 cycle to finish.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, range 2..16.

Ports:
- c200m  in  1  PI_CLK-derived 200 MHz clock; everything is synchronous to its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pi_a  in  2  Pi register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS.
- pi_wr_stb  in  1  one-cycle pulse per Pi write (already synchronised and edge-detected).
- pi_rd_stb  in  1  one-cycle pulse per Pi read.
- pi_d_in  in  16  Pi write data, valid while pi_wr_stb is high.
- pi_d_out  out  16  registered Pi read data.
- cmd_valid  out  1  the FIFO head is presented on cmd_*.
- cmd_ready  in  1  the bus engine accepts the head command.
- cmd_addr  out  24  68000 address.
- cmd_wdata  out  16  write data.
- cmd_fc  out  3  function code.
- cmd_rw  out  1  1 = read, 0 = write.
- cmd_uds_n / cmd_lds_n  out  1 each  data strobes, active-low.
- rsp_valid  in  1  one-cycle pulse when the bus engine finishes a cycle (S7).
- rsp_rdata  in  16  read data, valid while rsp_valid is high.
- txn_busy  out  1  at least one command is queued or in flight; this line feeds PI_TXN_IN_PROGRESS.
- q_full  out  1  the FIFO holds DEPTH entries.

## Operation
Staging registers are loaded on pi_wr_stb:
- DATA: wdata_stg <= d.
- ADDR_LO: addr_stg[15:0] <= d.
- ADDR_HI: this write commits an entry built from:
  - addr = {d[7:0], addr_stg[15:0]}
  - byte = d[8]
  - rw = d[9]
  - fc = d[15:13]
  - uds_n = byte ? addr_stg[0] : 0
  - lds_n = byte ? !addr_stg[0] : 0
  - wdata = wdata_stg
- STATUS write: when d[3] = 1, clear the overflow flag. All other bits are ignored.

FIFO rules:
- Push happens on an ADDR_HI write when the FIFO is not full.
- An ADDR_HI write while full drops the entry and sets sticky overflow.
- Full is judged on the pre-edge count. A pop in the same cycle does not make room.
- Pop happens on cmd_valid && cmd_ready. The popped entry's rw is copied into inflight_rw.
- Entries are issued in strict order. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave the count unchanged.

Outstanding counter:
- Width clog2(DEPTH+2).
- +1 on push, −1 on rsp_valid; both in the same cycle leave it unchanged.
- rsp_valid while the counter is 0 is ignored.
- txn_busy = (outstanding != 0).

Read responses:
- rsp_valid with inflight_rw = 1 captures rsp_rdata into rd_data and sets rd_valid.
- A write response leaves rd_data unchanged.

Pi reads (pi_d_out updates on pi_rd_stb):
- DATA: pi_d_out <= rd_data; rd_valid clears.
- STATUS: pi_d_out <= {12'b0, overflow, rd_valid, q_full, txn_busy}.
- ADDR_LO and ADDR_HI: pi_d_out <= 0.

When cmd_valid = 0, the cmd_* outputs hold idle values: addr 0, wdata 0, fc 7, rw 1, uds_n 1, lds_n 1.

## Timing
- Reset values: pi_d_out 0, cmd_valid 0, cmd_* at idle values, txn_busy 0, q_full 0. Staging registers, overflow, rd_valid, rd_data, pointers and counters all reset to 0.
- Reset asserted mid-operation empties the FIFO and discards any in-flight tracking. A rsp_valid that arrives after reset is then ignored.
- Push to cmd_valid: 1 cycle (pulse at edge N, cmd_valid high after edge N+1). txn_busy and q_full update at the same edge.
- cmd_* are stable while cmd_valid && !cmd_ready. The head is never withdrawn.
- After a pop, the next entry appears in the following cycle. Back-to-back pops are allowed when cmd_ready stays high.
- rsp_valid to txn_busy low: 1 cycle when it is the last outstanding transaction. It reaches the STATUS bits at the same edge.
- pi_d_out updates 1 cycle after pi_rd_stb and holds until the next pi_rd_stb.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs at their reset values immediately; cmd_fc = 7, cmd_rw = 1.
- Word write, cmd_ready held low for 10 cycles. Stimulus: DATA 0x1234, ADDR_LO 0x5678, ADDR_HI 0xA012 (fc 5, rw 0, word). Response: cmd_valid 1 cycle later with addr 0x125678, fc 5, uds_n 0, lds_n 0, wdata 0x1234, all stable for the 10 cycles; txn_busy = 1. Then ready pulse plus rsp_valid → txn_busy = 0 one cycle later.
- Byte read, odd address. Stimulus: ADDR_LO 0x0001, ADDR_HI 0x0300. Response: rw 1, uds_n 1, lds_n 0. Then rsp_valid with 0xBEEF → STATUS reads 0x0004 (rd_valid); DATA read returns 0xBEEF; the next STATUS read returns 0x0000.
- Overflow with DEPTH = 4 and ready = 0. Stimulus: 5 ADDR_HI pushes. Response: q_full after the 4th; the 5th is dropped and STATUS bit 3 = 1. With ready high, entries emerge in push order with no loss. A STATUS write of 0x0008 clears bit 3.
- Full with simultaneous pop: push while full in the same cycle as cmd_ready → push dropped, overflow set, count = 3 afterwards.
- Spurious completion: rsp_valid with nothing outstanding → txn_busy stays 0 and rd_valid unchanged.

Source files
------------

// File: rtl/pi_txn_queue.sv
// Pi-side command queue for the 68000 bus engine: stages Pi register writes into
// bus commands, buffers them in a FIFO and tracks outstanding cycles for busy/status.
module pi_txn_queue #(
  parameter int DEPTH = 4
) (
  input  logic        c200m,
  input  logic        rst,
  input  logic [1:0]  pi_a,
  input  logic        pi_wr_stb,
  input  logic        pi_rd_stb,
  input  logic [15:0] pi_d_in,
  output logic [15:0] pi_d_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic [2:0]  cmd_fc,
  output logic        cmd_rw,
  output logic        cmd_uds_n,
  output logic        cmd_lds_n,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        txn_busy,
  output logic        q_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 2);

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [2:0]  fc;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          new_entry;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [15:0]   wdata_stg;
  logic [15:0]   addr_stg;
  logic [15:0]   rd_data;
  logic          overflow;
  logic          rd_valid;
  logic          inflight_rw;
  logic          addr_hi_wr;
  logic          full;
  logic          push;
  logic          pop;
  logic          rsp_ok;

  assign addr_hi_wr = pi_wr_stb && (pi_a == REG_ADDR_HI);
  assign full       = (count == CW'(DEPTH));
  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign push       = addr_hi_wr && !full;
  assign pop        = (count != '0) && cmd_ready;
  assign rsp_ok     = rsp_valid && (outstanding != '0);

  always_comb begin
    new_entry.addr  = {pi_d_in[7:0], addr_stg};
    new_entry.wdata = wdata_stg;
    new_entry.fc    = pi_d_in[15:13];
    new_entry.rw    = pi_d_in[9];
    new_entry.uds_n = pi_d_in[8] & addr_stg[0];
    new_entry.lds_n = pi_d_in[8] & ~addr_stg[0];
  end

  always_ff @(posedge c200m) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  assign head      = mem[rd_ptr];
  assign cmd_valid = (count != '0);
  assign cmd_addr  = cmd_valid ? head.addr  : 24'h0;
  assign cmd_wdata = cmd_valid ? head.wdata : 16'h0;
  assign cmd_fc    = cmd_valid ? head.fc    : 3'd7;
  assign cmd_rw    = cmd_valid ? head.rw    : 1'b1;
  assign cmd_uds_n = cmd_valid ? head.uds_n : 1'b1;
  assign cmd_lds_n = cmd_valid ? head.lds_n : 1'b1;
  assign txn_busy  = (outstanding != '0);
  assign q_full    = full;

  always_ff @(posedge c200m or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      wdata_stg   <= '0;
      addr_stg    <= '0;
      rd_data     <= '0;
      overflow    <= 1'b0;
      rd_valid    <= 1'b0;
      inflight_rw <= 1'b0;
      pi_d_out    <= '0;
    end else begin
      if (pi_wr_stb && pi_a == REG_DATA)    wdata_stg <= pi_d_in;
      if (pi_wr_stb && pi_a == REG_ADDR_LO) addr_stg  <= pi_d_in;

      if (addr_hi_wr && full) begin
        overflow <= 1'b1;
      end else if (pi_wr_stb && pi_a == REG_STATUS && pi_d_in[3]) begin
        overflow <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        inflight_rw <= head.rw;
      end

      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end

      if (push && !rsp_ok) begin
        outstanding <= outstanding + OW'(1);
      end else if (rsp_ok && !push) begin
        outstanding <= outstanding - OW'(1);
      end

      // A response that lands in the same cycle as a DATA read wins, so no read data is lost.
      if (rsp_ok && inflight_rw) begin
        rd_data  <= rsp_rdata;
        rd_valid <= 1'b1;
      end else if (pi_rd_stb && pi_a == REG_DATA) begin
        rd_valid <= 1'b0;
      end

      if (pi_rd_stb) begin
        case (pi_a)
          REG_DATA:   pi_d_out <= rd_data;
          REG_STATUS: pi_d_out <= {12'b0, overflow, rd_valid, full, txn_busy};
          default:    pi_d_out <= 16'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pi_txn_queue.sv
// Scoreboard bench for pi_txn_queue: stimulus queues expected commands and Pi reads,
// a monitor compares them as the DUT issues commands and returns read data.
module tb_pi_txn_queue;

  logic        c200m = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pi_a = 2'd0;
  logic        pi_wr_stb = 1'b0;
  logic        pi_rd_stb = 1'b0;
  logic [15:0] pi_d_in = 16'h0;
  logic [15:0] pi_d_out;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [2:0]  cmd_fc;
  logic        cmd_rw;
  logic        cmd_uds_n;
  logic        cmd_lds_n;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_rdata = 16'h0;
  logic        txn_busy;
  logic        q_full;

  pi_txn_queue #(.DEPTH(4)) dut (
    .c200m(c200m), .rst(rst),
    .pi_a(pi_a), .pi_wr_stb(pi_wr_stb), .pi_rd_stb(pi_rd_stb),
    .pi_d_in(pi_d_in), .pi_d_out(pi_d_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_fc(cmd_fc),
    .cmd_rw(cmd_rw), .cmd_uds_n(cmd_uds_n), .cmd_lds_n(cmd_lds_n),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .txn_busy(txn_busy), .q_full(q_full)
  );

  always #5 c200m = ~c200m;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [2:0]  fc;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
  } exp_cmd_t;

  exp_cmd_t    cmd_q[$];
  logic [15:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        rd_pending = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_cmd_t mk(input logic [23:0] addr, input logic [15:0] wdata,
                                  input logic [2:0] fc, input logic rw,
                                  input logic uds_n, input logic lds_n);
    exp_cmd_t e;
    e.addr = addr; e.wdata = wdata; e.fc = fc; e.rw = rw; e.uds_n = uds_n; e.lds_n = lds_n;
    return e;
  endfunction

  // Monitor: commands are checked on each handshake, Pi reads one cycle after the strobe.
  always @(negedge c200m) begin
    exp_cmd_t e;
    logic [15:0] r;
    if (rd_pending) begin
      rd_pending = 1'b0;
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pi_read: got 0x%0h expected no read", pi_d_out);
      end else begin
        r = rd_q.pop_front();
        $display("pi read data=0x%04h", pi_d_out);
        chk("pi_d_out", {32'h0, pi_d_out}, {32'h0, r});
      end
    end
    if (pi_rd_stb && !rst) rd_pending = 1'b1;
    if (cmd_valid && cmd_ready && !rst) begin
      $display("cmd addr=0x%06h wdata=0x%04h fc=%0d rw=%b uds_n=%b lds_n=%b",
               cmd_addr, cmd_wdata, cmd_fc, cmd_rw, cmd_uds_n, cmd_lds_n);
      if (cmd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cmd_issue: got addr 0x%0h expected no command", cmd_addr);
      end else begin
        e = cmd_q.pop_front();
        chk("cmd_fields", {2'b0, cmd_addr, cmd_wdata, cmd_fc, cmd_rw, cmd_uds_n, cmd_lds_n},
            {2'b0, e});
      end
    end
  end

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge c200m); #1;
    pi_a = a; pi_d_in = d; pi_wr_stb = 1'b1;
    @(posedge c200m); #1;
    pi_wr_stb = 1'b0;
  endtask

  task automatic pi_read(input logic [1:0] a, input logic [15:0] exp);
    @(posedge c200m); #1;
    pi_a = a; pi_rd_stb = 1'b1; rd_q.push_back(exp);
    @(posedge c200m); #1;
    pi_rd_stb = 1'b0;
  endtask

  task automatic pulse_ready();
    @(posedge c200m); #1; cmd_ready = 1'b1;
    @(posedge c200m); #1; cmd_ready = 1'b0;
  endtask

  task automatic rsp(input logic [15:0] d);
    @(posedge c200m); #1; rsp_valid = 1'b1; rsp_rdata = d;
    @(posedge c200m); #1; rsp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge c200m);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_valid"}, {47'h0, cmd_valid}, 48'h0);
    chk({tag, "_cmd_addr"},  {24'h0, cmd_addr}, 48'h0);
    chk({tag, "_cmd_wdata"}, {32'h0, cmd_wdata}, 48'h0);
    chk({tag, "_cmd_fc"},    {45'h0, cmd_fc}, 48'h7);
    chk({tag, "_cmd_rw"},    {47'h0, cmd_rw}, 48'h1);
    chk({tag, "_cmd_strb"},  {46'h0, cmd_uds_n, cmd_lds_n}, 48'h3);
    chk({tag, "_txn_busy"},  {47'h0, txn_busy}, 48'h0);
    chk({tag, "_q_full"},    {47'h0, q_full}, 48'h0);
    chk({tag, "_pi_d_out"},  {32'h0, pi_d_out}, 48'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    idle(2);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Word write held off by ready low for 10 cycles
    pi_write(2'd0, 16'h1234);
    pi_write(2'd1, 16'h5678);
    chk("pre_push_valid", {47'h0, cmd_valid}, 48'h0);
    pi_write(2'd2, 16'hA012);
    chk("push_valid", {47'h0, cmd_valid}, 48'h1);
    chk("push_busy", {47'h0, txn_busy}, 48'h1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("hold_cmd", {1'b0, cmd_valid, cmd_addr, cmd_wdata, cmd_fc, cmd_rw, cmd_uds_n, cmd_lds_n},
          {1'b0, 1'b1, 24'h125678, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b0});
    end
    cmd_q.push_back(mk(24'h125678, 16'h1234, 3'd5, 1'b0, 1'b0, 1'b0));
    pulse_ready();
    chk("after_pop_valid", {47'h0, cmd_valid}, 48'h0);
    chk("inflight_busy", {47'h0, txn_busy}, 48'h1);
    rsp(16'h0000);
    chk("done_busy", {47'h0, txn_busy}, 48'h0);

    // Byte read at an odd address
    pi_write(2'd1, 16'h0001);
    pi_write(2'd2, 16'h0300);
    chk("byte_strobes", {45'h0, cmd_rw, cmd_uds_n, cmd_lds_n}, 48'b110);
    cmd_q.push_back(mk(24'h000001, 16'h1234, 3'd0, 1'b1, 1'b1, 1'b0));
    pulse_ready();
    rsp(16'hBEEF);
    pi_read(2'd3, 16'h0004);
    pi_read(2'd0, 16'hBEEF);
    pi_read(2'd3, 16'h0000);

    // Overflow: five pushes into a four-deep queue
    for (int i = 0; i < 5; i++) begin
      pi_write(2'd0, 16'hA000 + 16'(i));
      pi_write(2'd1, 16'h0100 * 16'(i) + 16'h0002);
      pi_write(2'd2, 16'h2000 | 16'(i));
      if (i < 4) cmd_q.push_back(mk({8'(i), 16'h0100 * 16'(i) + 16'h0002},
                                    16'hA000 + 16'(i), 3'd1, 1'b0, 1'b0, 1'b0));
      if (i == 3) chk("full_after_4", {47'h0, q_full}, 48'h1);
    end
    pi_read(2'd3, 16'h000B);
    @(posedge c200m); #1; cmd_ready = 1'b1;
    idle(6);
    cmd_ready = 1'b0;
    chk("drained_valid", {47'h0, cmd_valid}, 48'h0);
    chk("drained_q", 48'(cmd_q.size()), 48'h0);
    pi_read(2'd3, 16'h0009);
    pi_write(2'd3, 16'h0008);
    pi_read(2'd3, 16'h0001);
    repeat (4) rsp(16'h7777);
    chk("ovf_busy_clear", {47'h0, txn_busy}, 48'h0);
    pi_read(2'd3, 16'h0000);

    // Push while full in the same cycle as a pop: push dropped
    pi_write(2'd1, 16'h0040);
    for (int i = 0; i < 4; i++) begin
      pi_write(2'd0, 16'hC000 + 16'(i));
      pi_write(2'd2, 16'h4200 | (16'h0010 + 16'(i)));
      cmd_q.push_back(mk({8'h10 + 8'(i), 16'h0040}, 16'hC000 + 16'(i), 3'd2, 1'b1, 1'b0, 1'b0));
    end
    chk("full_again", {47'h0, q_full}, 48'h1);
    @(posedge c200m); #1;
    pi_a = 2'd2; pi_d_in = 16'h4214; pi_wr_stb = 1'b1; cmd_ready = 1'b1;
    @(posedge c200m); #1;
    pi_wr_stb = 1'b0; cmd_ready = 1'b0;
    chk("simul_full", {47'h0, q_full}, 48'h0);
    chk("simul_valid", {47'h0, cmd_valid}, 48'h1);
    pi_read(2'd3, 16'h0009);
    @(posedge c200m); #1; cmd_ready = 1'b1;
    idle(5);
    cmd_ready = 1'b0;
    chk("simul_drained", {47'h0, cmd_valid}, 48'h0);
    chk("simul_q", 48'(cmd_q.size()), 48'h0);
    pi_write(2'd3, 16'h0008);
    rsp(16'h1111);
    rsp(16'h2222);
    rsp(16'h3333);
    rsp(16'hBEEF);
    chk("simul_busy", {47'h0, txn_busy}, 48'h0);
    pi_read(2'd3, 16'h0004);
    pi_read(2'd0, 16'hBEEF);

    // Spurious completion with nothing outstanding
    rsp(16'h5555);
    chk("spurious_busy", {47'h0, txn_busy}, 48'h0);
    pi_read(2'd3, 16'h0000);
    pi_read(2'd0, 16'hBEEF);

    // Asynchronous reset mid-operation
    pi_write(2'd1, 16'h0100);
    pi_write(2'd2, 16'h2000);
    pi_write(2'd2, 16'h2001);
    cmd_q.push_back(mk(24'h000100, 16'hC003, 3'd1, 1'b0, 1'b0, 1'b0));
    pulse_ready();
    @(posedge c200m); #3;
    rst = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    idle(2);
    rst = 1'b0;
    rsp(16'h9999);
    chk("post_reset_busy", {47'h0, txn_busy}, 48'h0);
    pi_read(2'd3, 16'h0000);
    pi_read(2'd0, 16'h0000);
    pi_write(2'd2, 16'h2005);
    cmd_q.push_back(mk(24'h050000, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0));
    pulse_ready();

    idle(3);
    chk("cmd_q_empty", 48'(cmd_q.size()), 48'h0);
    chk("rd_q_empty", 48'(rd_q.size()), 48'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
